aiv_input_sync_filt: RTL and testbench

- Parameterised successor to the AIV 2-stage input synchroniser.
- Synchronises WIDTH async AIV inputs (RGB111 + csync by default) to clk.
- Uses a configurable-depth synchroniser chain, then a per-channel glitch filter built on a stability counter.
- Emits single-cycle rise/fall strobes so downstream sync-separator and pixel-capture logic need no private edge detectors.

---
 rtl/aiv_pkg.sv | 23 ++
 rtl/aiv_glitch_filter.sv | 71 +++++++
 rtl/aiv_input_sync_filt.sv | 69 ++++++
 tb/tb_aiv_input_sync_filt.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aiv_pkg.sv
// aiv_pkg: shared constants for the AIV input path.
//   Channel bit positions on the {R,G,B,csync} bus, default bus width,
//   the idle level (csync high, colours low) and a counter-width helper
//   used by the glitch filter.
package aiv_pkg;

    localparam int unsigned AIV_CH_R     = 3;
    localparam int unsigned AIV_CH_G     = 2;
    localparam int unsigned AIV_CH_B     = 1;
    localparam int unsigned AIV_CH_CSYNC = 0;

    localparam int unsigned AIV_WIDTH = 4;

    localparam logic [AIV_WIDTH-1:0] AIV_IDLE = 4'b0001;

    typedef logic [AIV_WIDTH-1:0] aiv_bus_t;

    // Bits needed to count 0..len; never less than one bit.
    function automatic int unsigned filt_cnt_width(input int unsigned len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/aiv_glitch_filter.sv
// aiv_glitch_filter: single-channel glitch filter with edge strobes.
//   A new level on sync_in is accepted only after it has differed from
//   data_out for FILTER_LEN consecutive cycles; one cycle of agreement
//   restarts the count. bypass makes data_out follow sync_in directly.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   sync_in  - synchronised input level
//   bypass   - 1 = filter disabled (synchronous)
//   data_out - filtered level
//   rise     - 1-cycle strobe, registered with data_out going 0->1
//   fall     - 1-cycle strobe, registered with data_out going 1->0
module aiv_glitch_filter
    import aiv_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 3,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_in,
    input  logic bypass,
    output logic data_out,
    output logic rise,
    output logic fall
);

    localparam int unsigned      CNT_W    = filt_cnt_width(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, fall_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (bypass) begin
            level_d = sync_in;
            cnt_d   = '0;
        end else if (sync_in == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_in;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Strobes are computed from the next level so they appear in the same
    // cycle as the new data_out value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            level_q <= RESET_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign data_out = level_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule

// File: rtl/aiv_input_sync_filt.sv
// aiv_input_sync_filt: synchroniser + glitch filter for the AIV inputs.
//   Each of WIDTH asynchronous inputs passes through a SYNC_STAGES-deep
//   flop chain, then a per-channel stability filter that also produces
//   registered rise/fall strobes.
// Ports:
//   clk           - system clock
//   reset_n       - asynchronous active-low reset
//   async_in      - raw asynchronous inputs, {R,G,B,csync} by default
//   filter_bypass - 1 = filter disabled (synchronous to clk)
//   sync_out      - last synchroniser stage
//   data_out      - filtered, synchronised level
//   rise / fall   - 1-cycle strobes on data_out transitions
module aiv_input_sync_filt
    import aiv_pkg::*;
#(
    parameter int unsigned      WIDTH       = AIV_WIDTH,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      FILTER_LEN  = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = AIV_IDLE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    input  logic             filter_bypass,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (SYNC_STAGES < 2) begin : gen_bad_stages
        $error("aiv_input_sync_filt: SYNC_STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : gen_bad_filter
        $error("aiv_input_sync_filt: FILTER_LEN must be >= 1");
    end

    // chain_q[0] samples the pins; no logic between stages.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            chain_q[0] <= async_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                chain_q[k] <= chain_q[k-1];
            end
        end
    end

    assign sync_out = chain_q[SYNC_STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : gen_filt
        aiv_glitch_filter #(
            .FILTER_LEN  (FILTER_LEN),
            .RESET_VALUE (RESET_VALUE[i])
        ) u_filt (
            .clk      (clk),
            .reset_n  (reset_n),
            .sync_in  (sync_out[i]),
            .bypass   (filter_bypass),
            .data_out (data_out[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

endmodule

// File: tb/tb_aiv_input_sync_filt.sv
// Bench for aiv_input_sync_filt: a default instance (A) and a wide instance
// (B: WIDTH=8, SYNC_STAGES=3, FILTER_LEN=1, reset 8'h00) share clock, reset
// and bypass. A behavioural model predicts every post-edge output; predictions
// are queued at drive time and compared mid-cycle after each rising edge.
module tb_aiv_input_sync_filt;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       filter_bypass = 1'b0;
    logic [3:0] async_a = 4'h0;
    logic [7:0] async_b = 8'h00;

    logic [3:0] sync_a, data_a, rise_a, fall_a;
    logic [7:0] sync_b, data_b, rise_b, fall_b;

    always #5 clk = ~clk;

    aiv_input_sync_filt u_dut_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .async_in      (async_a),
        .filter_bypass (filter_bypass),
        .sync_out      (sync_a),
        .data_out      (data_a),
        .rise          (rise_a),
        .fall          (fall_a)
    );

    aiv_input_sync_filt #(
        .WIDTH       (8),
        .SYNC_STAGES (3),
        .FILTER_LEN  (1),
        .RESET_VALUE (8'h00)
    ) u_dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .async_in      (async_b),
        .filter_bypass (filter_bypass),
        .sync_out      (sync_b),
        .data_out      (data_b),
        .rise          (rise_b),
        .fall          (fall_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_stage [2][3];
    logic [7:0] m_q [2];
    logic [7:0] m_r [2];
    logic [7:0] m_f [2];
    int         m_cnt [2][8];

    function automatic int stages(input int d); return (d == 0) ? 2 : 3; endfunction
    function automatic int flen(input int d);   return (d == 0) ? 3 : 1; endfunction
    function automatic int chans(input int d);  return (d == 0) ? 4 : 8; endfunction
    function automatic logic [7:0] rval(input int d); return (d == 0) ? 8'h01 : 8'h00; endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) m_stage[d][k] = rval(d);
            m_q[d] = rval(d);
            m_r[d] = 8'h00;
            m_f[d] = 8'h00;
            for (int c = 0; c < 8; c++) m_cnt[d][c] = 0;
        end
    endtask

    task automatic model_step();
        logic [7:0] s, nq;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            s  = m_stage[d][stages(d)-1];
            nq = m_q[d];
            for (int c = 0; c < chans(d); c++) begin
                if (filter_bypass) begin
                    nq[c] = s[c];
                    m_cnt[d][c] = 0;
                end else if (s[c] == m_q[d][c]) begin
                    m_cnt[d][c] = 0;
                end else if (m_cnt[d][c] + 1 == flen(d)) begin
                    nq[c] = s[c];
                    m_cnt[d][c] = 0;
                end else begin
                    m_cnt[d][c]++;
                end
            end
            m_r[d] = nq & ~m_q[d];
            m_f[d] = ~nq & m_q[d];
            m_q[d] = nq;
            for (int k = stages(d) - 1; k > 0; k--) m_stage[d][k] = m_stage[d][k-1];
            m_stage[d][0] = (d == 0) ? {4'h0, async_a} : async_b;
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [3:0] sa, da, ra, fa;
        logic [7:0] sb, db, rb, fb;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(posedge clk) begin
        #4;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("a_sync", {28'h0, sync_a}, {28'h0, mon_e.sa});
            check("a_data", {28'h0, data_a}, {28'h0, mon_e.da});
            check("a_rise", {28'h0, rise_a}, {28'h0, mon_e.ra});
            check("a_fall", {28'h0, fall_a}, {28'h0, mon_e.fa});
            check("b_sync", {24'h0, sync_b}, {24'h0, mon_e.sb});
            check("b_data", {24'h0, data_b}, {24'h0, mon_e.db});
            check("b_rise", {24'h0, rise_b}, {24'h0, mon_e.rb});
            check("b_fall", {24'h0, fall_b}, {24'h0, mon_e.fb});
        end
    end

    // Called right after a falling edge with inputs already set; returns at
    // the next falling edge. rst_mid asserts reset between edges first.
    task automatic tick(input bit rst_mid);
        exp_t e;
        if (rst_mid) begin
            #2;
            reset_n = 1'b0;
            #1;
            check("rst_imm_data", {28'h0, data_a}, 32'h1);
            check("rst_imm_sync", {28'h0, sync_a}, 32'h1);
            check("rst_imm_strb", {24'h0, rise_a, fall_a}, 32'h0);
            check("rst_imm_b",    {24'h0, data_b}, 32'h0);
        end
        model_step();
        e.sa = m_stage[0][1][3:0];
        e.da = m_q[0][3:0];
        e.ra = m_r[0][3:0];
        e.fa = m_f[0][3:0];
        e.sb = m_stage[1][2];
        e.db = m_q[1];
        e.rb = m_r[1];
        e.fb = m_f[1];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    int lat_a, lat_b, n_r, n_f, idx_r, idx_f;

    initial begin
        model_reset();

        // Reset held: inputs toggle, outputs must stay at reset values.
        async_a = 4'hF; tick(0);
        async_a = 4'h0; tick(0);
        async_a = 4'hA; async_b = 8'h5A; tick(0);
        async_a = 4'h5; tick(0);

        // Release at idle; no strobes expected.
        async_a = 4'b0001;
        async_b = 8'h00;
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) tick(0);

        // Clean step on R (A) and all-bits step on B.
        async_a = 4'b1001;
        async_b = 8'hFF;
        lat_a = -1; lat_b = -1; n_r = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(0);
            if (rise_a[3]) begin
                n_r++;
                if (lat_a < 0) lat_a = k;
            end
            if (rise_b == 8'hFF && lat_b < 0) lat_b = k;
        end
        check("clean_latency", lat_a, 5);
        check("clean_pulses", n_r, 1);
        check("sweep_latency", lat_b, 4);

        // Glitch of 2 cycles on csync is rejected.
        n_f = 0;
        async_a = 4'b1000;
        for (int k = 0; k < 2; k++) begin tick(0); if (fall_a[0]) n_f++; end
        async_a = 4'b1001;
        for (int k = 0; k < 10; k++) begin tick(0); if (fall_a[0]) n_f++; end
        check("glitch2_fall", n_f, 0);

        // 3-cycle low is accepted, then returns high.
        n_f = 0; n_r = 0;
        async_a = 4'b1000;
        for (int k = 0; k < 3; k++) begin tick(0); n_f += int'(fall_a[0]); end
        async_a = 4'b1001;
        for (int k = 0; k < 12; k++) begin
            tick(0);
            n_f += int'(fall_a[0]);
            n_r += int'(rise_a[0]);
        end
        check("low3_fall", n_f, 1);
        check("low3_rise", n_r, 1);

        // Bypass: 1-cycle pulse on B channel passes with 3-edge latency.
        filter_bypass = 1'b1;
        idx_r = -1; idx_f = -1;
        async_a = 4'b1011;
        for (int k = 1; k <= 7; k++) begin
            tick(0);
            if (k == 1) async_a = 4'b1001;
            if (rise_a[1] && idx_r < 0) idx_r = k;
            if (fall_a[1] && idx_f < 0) idx_f = k;
        end
        check("byp_rise_edge", idx_r, 3);
        check("byp_fall_edge", idx_f, 4);

        // Bypass asserted with cnt=2 pending takes effect on the next edge.
        filter_bypass = 1'b0;
        async_a = 4'b1011;
        for (int k = 0; k < 4; k++) tick(0);
        check("pend_hold", {31'h0, data_a[1]}, 32'h0);
        filter_bypass = 1'b1;
        tick(0);
        check("pend_byp_data", {31'h0, data_a[1]}, 32'h1);
        check("pend_byp_rise", {31'h0, rise_a[1]}, 32'h1);
        filter_bypass = 1'b0;
        async_a = 4'b1001;
        for (int k = 0; k < 6; k++) tick(0);

        // Random traffic, sparse per-bit changes and occasional bypass.
        for (int k = 0; k < 300; k++) begin
            async_a = async_a ^ 4'($urandom & $urandom);
            async_b = async_b ^ 8'($urandom & $urandom & $urandom);
            filter_bypass = ($urandom_range(0, 15) == 0);
            tick(0);
        end

        // Async reset in the middle of a count.
        filter_bypass = 1'b0;
        async_a = 4'b0001;
        async_b = 8'h00;
        for (int k = 0; k < 12; k++) tick(0);
        async_a = 4'b0101;
        tick(0);
        tick(0);
        tick(1);
        tick(0);
        reset_n = 1'b1;
        lat_a = -1; n_r = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(0);
            if (rise_a[2]) begin
                n_r++;
                if (lat_a < 0) lat_a = k;
            end
        end
        check("rst_relatency", lat_a, 5);
        check("rst_repulses", n_r, 1);

        check("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
